grid_initializer: RTL and testbench

Sweeps the fluid-state BRAM once per request and writes an initial lattice into every cell: nine 8-bit D2Q9 populations per word, barrier cells (all populations 8'hFF, which the display stage draws black) on the domain border and on a square obstacle, and equilibrium populations everywhere else. It sits upstream of the pixel colour stage and the solver, on the BRAM write port, and runs after reset or whenever the user requests a restart.

---
 rtl/fluid_pkg.sv | 33 +++
 rtl/cell_classifier.sv | 40 ++++
 rtl/grid_initializer.sv | 153 +++++++++++++++
 tb/tb_grid_initializer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fluid_pkg.sv
// Shared lattice constants and types for the D2Q9 fluid pipeline (initializer, display, solver).
package fluid_pkg;

  localparam int         GRID_W       = 205;
  localparam int         GRID_H       = 154;
  localparam logic [7:0] BARRIER_BYTE = 8'hFF;

  typedef enum logic [3:0] {
    DIR_REST = 4'd0,
    DIR_E    = 4'd1,
    DIR_N    = 4'd2,
    DIR_W    = 4'd3,
    DIR_S    = 4'd4,
    DIR_NE   = 4'd5,
    DIR_NW   = 4'd6,
    DIR_SW   = 4'd7,
    DIR_SE   = 4'd8
  } dir_e;

  typedef logic [8:0][7:0] cell_word_t;

  // Listed f8 down to f0; both sets sum to 144 so total mass matches either way.
  localparam cell_word_t REST_POP   = {8'd4, 8'd4, 8'd4, 8'd4, 8'd16, 8'd16, 8'd16, 8'd16, 8'd64};
  localparam cell_word_t INFLOW_POP = {8'd6, 8'd2, 8'd2, 8'd6, 8'd16, 8'd8, 8'd16, 8'd24, 8'd64};
  localparam cell_word_t BARRIER_WORD = {9{BARRIER_BYTE}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/cell_classifier.sv
// Combinational: maps a cell coordinate plus latched obstacle/inflow settings to its initial D2Q9 word.
module cell_classifier
  import fluid_pkg::*;
(
  input  logic [7:0]  i_x,
  input  logic [7:0]  i_y,
  input  logic [7:0]  i_obs_x,
  input  logic [7:0]  i_obs_y,
  input  logic [5:0]  i_obs_r,
  input  logic        i_inflow,
  output cell_word_t  o_word
);

  logic signed [8:0] w_dx;
  logic signed [8:0] w_dy;
  logic        [8:0] w_adx;
  logic        [8:0] w_ady;
  logic              w_border;
  logic              w_obstacle;

  assign w_dx  = $signed({1'b0, i_x}) - $signed({1'b0, i_obs_x});
  assign w_dy  = $signed({1'b0, i_y}) - $signed({1'b0, i_obs_y});
  assign w_adx = w_dx[8] ? $unsigned(-w_dx) : $unsigned(w_dx);
  assign w_ady = w_dy[8] ? $unsigned(-w_dy) : $unsigned(w_dy);

  assign w_border   = (i_x == 8'd0) || (i_x == 8'(GRID_W - 1)) ||
                      (i_y == 8'd0) || (i_y == 8'(GRID_H - 1));
  // Off-grid parts of the square never match a real coordinate, so clipping is implicit.
  assign w_obstacle = (w_adx <= {3'b000, i_obs_r}) && (w_ady <= {3'b000, i_obs_r});

  always_comb begin
    o_word = REST_POP;
    if (w_border || w_obstacle) begin
      o_word = BARRIER_WORD;
    end else if (i_inflow) begin
      o_word = INFLOW_POP;
    end
  end

endmodule

// File: rtl/grid_initializer.sv
// Sweeps every BRAM cell once per accepted start, one registered write per unheld cycle; hold_in stalls the sweep.
// Cell k is written from edge E(k+1) after acceptance at E0; done_out pulses one cycle after the last write.
module grid_initializer
  import fluid_pkg::*;
#(
  parameter int BRAM_DEPTH = 31570
) (
  input  logic                          pixel_clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  input  logic                          hold_in,
  input  logic                          inflow_en_in,
  input  logic [7:0]                    obs_x_in,
  input  logic [7:0]                    obs_y_in,
  input  logic [5:0]                    obs_r_in,
  output logic [$clog2(BRAM_DEPTH)-1:0] addr_out,
  output logic [8:0][7:0]               data_out,
  output logic                          we_out,
  output logic                          busy_out,
  output logic                          done_out
);

  localparam int ADDR_W = $clog2(BRAM_DEPTH);

  state_e            r_state;
  logic [7:0]        r_x;
  logic [7:0]        r_y;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inflow;
  logic [7:0]        r_obs_x;
  logic [7:0]        r_obs_y;
  logic [5:0]        r_obs_r;
  logic [ADDR_W-1:0] r_addr_out;
  cell_word_t        r_data_out;
  logic              r_we;
  logic              r_busy;
  logic              r_done;

  state_e            w_state_nxt;
  logic [7:0]        w_x_nxt;
  logic [7:0]        w_y_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_latch;
  logic              w_emit;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_last;
  cell_word_t        w_word;

  cell_classifier u_classifier (
    .i_x      (r_x),
    .i_y      (r_y),
    .i_obs_x  (r_obs_x),
    .i_obs_y  (r_obs_y),
    .i_obs_r  (r_obs_r),
    .i_inflow (r_inflow),
    .o_word   (w_word)
  );

  assign w_last = (r_addr == ADDR_W'(BRAM_DEPTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_addr_nxt  = r_addr;
    w_latch     = 1'b0;
    w_emit      = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_in) begin
          w_state_nxt = ST_SWEEP;
          w_x_nxt     = 8'd0;
          w_y_nxt     = 8'd0;
          w_addr_nxt  = '0;
          w_latch     = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_SWEEP: begin
        // A held cycle leaves the counters alone so the same cell is re-emitted next time.
        if (!hold_in) begin
          w_emit = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_addr_nxt = r_addr + ADDR_W'(1);
            if (r_x == 8'(GRID_W - 1)) begin
              w_x_nxt = 8'd0;
              w_y_nxt = r_y + 8'd1;
            end else begin
              w_x_nxt = r_x + 8'd1;
            end
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_state    <= ST_IDLE;
      r_x        <= 8'd0;
      r_y        <= 8'd0;
      r_addr     <= '0;
      r_inflow   <= 1'b0;
      r_obs_x    <= 8'd0;
      r_obs_y    <= 8'd0;
      r_obs_r    <= 6'd0;
      r_addr_out <= '0;
      r_data_out <= '0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_addr  <= w_addr_nxt;
      if (w_latch) begin
        r_inflow <= inflow_en_in;
        r_obs_x  <= obs_x_in;
        r_obs_y  <= obs_y_in;
        r_obs_r  <= obs_r_in;
      end
      if (w_emit) begin
        r_addr_out <= r_addr;
        r_data_out <= w_word;
      end
      r_we   <= w_emit;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign addr_out = r_addr_out;
  assign data_out = r_data_out;
  assign we_out   = r_we;
  assign busy_out = r_busy;
  assign done_out = r_done;

endmodule

// File: tb/tb_grid_initializer.sv
// Directed bench for grid_initializer: full sweeps with and without hold, mid-sweep reset, back-to-back start.
module tb_grid_initializer;

  localparam logic [71:0] W_FF     = {9{8'hFF}};
  localparam logic [71:0] W_REST   = 72'h04040404_10101010_40;
  localparam logic [71:0] W_INFLOW = 72'h06020206_10081018_40;

  logic        clk = 1'b0;
  logic        rst, start, hold, inflow;
  logic [7:0]  obs_x, obs_y;
  logic [5:0]  obs_r;
  logic [14:0] addr;
  logic [8:0][7:0] data;
  logic        we, busy, done;

  always #5 clk = ~clk;

  grid_initializer #(.BRAM_DEPTH(31570)) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .start_in     (start),
    .hold_in      (hold),
    .inflow_en_in (inflow),
    .obs_x_in     (obs_x),
    .obs_y_in     (obs_y),
    .obs_r_in     (obs_r),
    .addr_out     (addr),
    .data_out     (data),
    .we_out       (we),
    .busy_out     (busy),
    .done_out     (done)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Free-running edge counter and write/done monitor, all sampled on the falling edge.
  int          cyc = 0;
  int          nwrites = 0, order_err = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
  int          dup_done = 0, busy_done = 0, last_addr = -1;
  logic        prev_done = 1'b0;
  logic [71:0] cap [0:7];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) begin
      if (!((int'(addr) == last_addr + 1) || (addr == 15'd0 && last_addr != 0)))
        order_err <= order_err + 1;
      last_addr <= int'(addr);
      nwrites   <= nwrites + 1;
      if (addr == 15'd31569) last_wr_cyc <= cyc;
      case (addr)
        15'd0:     cap[0] <= data;
        15'd206:   cap[1] <= data;
        15'd15885: cap[2] <= data;
        15'd15879: cap[3] <= data;
        15'd15880: cap[4] <= data;
        15'd15890: cap[5] <= data;
        15'd15891: cap[6] <= data;
        15'd2060:  cap[7] <= data;
        default: ;
      endcase
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      if (prev_done) dup_done <= dup_done + 1;
      if (busy) busy_done <= busy_done + 1;
    end
    prev_done <= done;
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int c0, base_w, base_d, guard, mw, held, s;

    rst = 1'b1; start = 1'b0; hold = 1'b0; inflow = 1'b0;
    obs_x = 8'd100; obs_y = 8'd77; obs_r = 6'd5;
    repeat (3) tick();
    check("rst_addr", 72'(addr), 72'd0);
    check("rst_data", data, 72'd0);
    check("rst_ctl", {69'd0, we, busy, done}, 72'd0);
    rst = 1'b0;
    tick();

    // Sweep 1: inflow off, obstacle (100,77,5), no hold.
    base_w = nwrites; base_d = done_cnt;
    start = 1'b1;
    tick();
    c0 = cyc;
    start = 1'b0;
    check("s1_accept_busy", {70'd0, busy, we}, 72'b10);
    guard = 0;
    while (done_cnt == base_d && guard < 31700) begin tick(); guard++; end
    check("s1_done_seen", 72'(done_cnt - base_d), 72'd1);
    check("s1_writes", 72'(nwrites - base_w), 72'd31570);
    check("s1_done_lat", 72'(done_cyc - c0), 72'd31571);
    check("s1_done_after_last", 72'(done_cyc - last_wr_cyc), 72'd1);
    check("s1_addr0", cap[0], W_FF);
    check("s1_addr206", cap[1], W_REST);
    check("s1_obs_centre", cap[2], W_FF);
    check("s1_obs_94_77", cap[3], W_REST);
    check("s1_obs_95_77", cap[4], W_FF);
    check("s1_obs_105_77", cap[5], W_FF);
    check("s1_obs_106_77", cap[6], W_REST);
    tick();
    check("s1_done_one_cycle", {70'd0, done, busy}, 72'd0);

    // Sweep 2: inflow on, start held high, inputs changed after acceptance, 30% hold.
    inflow = 1'b1; start = 1'b1; hold = 1'b0;
    base_w = nwrites; base_d = done_cnt;
    tick();
    c0 = cyc;
    inflow = 1'b0; obs_x = 8'd10; obs_y = 8'd10; obs_r = 6'd0;
    mw = 0; held = 0;
    while (mw < 31570) begin
      hold = ($urandom_range(0, 9) < 3);
      tick();
      if (hold) held++;
      else mw++;
    end
    hold = 1'b0;
    guard = 0;
    while (done_cnt == base_d && guard < 10) begin tick(); guard++; end
    check("s2_done_seen", 72'(done_cnt - base_d), 72'd1);
    check("s2_writes", 72'(nwrites - base_w), 72'd31570);
    check("s2_done_lat", 72'(done_cyc - c0), 72'(31571 + held));
    check("s2_cell_10_10", cap[7], W_INFLOW);
    s = 0;
    for (int i = 0; i < 9; i++) s += int'(cap[7][i*8 +: 8]);
    check("s2_inflow_sum", 72'(s), 72'd144);
    check("s2_obs_latched", cap[2], W_FF);

    // start still high: a new sweep is accepted on the edge after done_out.
    tick();
    check("restart_accept", {70'd0, busy, we}, 72'b10);
    tick();
    check("restart_first", {56'd0, we, addr}, {56'd0, 1'b1, 15'd0});
    base_w = nwrites;
    guard = 0;
    while ((nwrites - base_w) < 4999 && guard < 6000) begin tick(); guard++; end
    check("s3_reached_5000", 72'(addr), 72'd4999);

    // Reset mid-sweep with start also high: reset wins, no done afterwards.
    rst = 1'b1;
    tick();
    start = 1'b0;
    check("midrst_addr", 72'(addr), 72'd0);
    check("midrst_data", data, 72'd0);
    check("midrst_ctl", {69'd0, we, busy, done}, 72'd0);
    rst = 1'b0;
    base_d = done_cnt;
    repeat (40) tick();
    check("midrst_no_done", 72'(done_cnt - base_d), 72'd0);
    check("midrst_idle", {70'd0, busy, we}, 72'd0);

    // Fresh start after the abandoned sweep begins again at address 0.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("s4_first", {56'd0, we, addr}, {56'd0, 1'b1, 15'd0});
    check("s4_first_data", data, W_FF);
    tick();
    check("s4_second", {56'd0, we, addr}, {56'd0, 1'b1, 15'd1});

    check("addr_order", 72'(order_err), 72'd0);
    check("done_single_pulse", 72'(dup_done), 72'd0);
    check("busy_low_at_done", 72'(busy_done), 72'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
